// File: rtl/msa_compressor_arbiter.sv
// msa_compressor_arbiter
//   Shares a single msa_compressor between NUM_REQ hash requesters. A
//   round-robin scan picks one pending request, its context and 64-word
//   message schedule are buffered, handed to the compressor over two
//   independent valid/ready handshakes, and the compressor's result is
//   returned to the same requester. Only one job is in flight at a time.
//
//   Ports
//     clk, rst                         clock, asynchronous active-high reset
//     req_vld / req_rdy                per-requester job handshake (rdy one-hot or zero)
//     req_ctx / req_w                  per-requester context and message schedule
//     rsp_vld / rsp_rdy                per-requester result handshake (vld one-hot or zero)
//     rsp_ctx                          result context, shared by all requesters
//     cmp_ctx_in_vld/_rdy, cmp_ctx_in  context handshake towards the compressor
//     cmp_w_vld/_rdy, cmp_w            schedule handshake towards the compressor
//     cmp_ctx_out_vld/_rdy, cmp_ctx_out  result handshake from the compressor
//     busy                             high whenever a job is owned
//     grant_id                         current or most recent owner
//     jobs_done                        completed-job counter, wraps at 16 bits

package msa_compressor_arbiter_pkg;
  // state[0] holds working variable a, state[7] holds h.
  typedef struct packed {
    logic [7:0][31:0] state;
  } ShaContext;
endpackage

module msa_compressor_arbiter
  import msa_compressor_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_vld,
  output logic [NUM_REQ-1:0]                req_rdy,
  input  ShaContext [NUM_REQ-1:0]           req_ctx,
  input  logic [NUM_REQ-1:0][63:0][31:0]    req_w,
  output logic [NUM_REQ-1:0]                rsp_vld,
  input  logic [NUM_REQ-1:0]                rsp_rdy,
  output ShaContext                         rsp_ctx,
  output logic                              cmp_ctx_in_vld,
  input  logic                              cmp_ctx_in_rdy,
  output ShaContext                         cmp_ctx_in,
  output logic                              cmp_w_vld,
  input  logic                              cmp_w_rdy,
  output logic [63:0][31:0]                 cmp_w,
  input  logic                              cmp_ctx_out_vld,
  output logic                              cmp_ctx_out_rdy,
  input  ShaContext                         cmp_ctx_out,
  output logic                              busy,
  output logic [ID_W-1:0]                   grant_id,
  output logic [15:0]                       jobs_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_ISSUE,
    S_WAIT,
    S_RELEASE,
    S_RESPOND
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  ShaContext         ctx_buf;
  logic [63:0][31:0] w_buf;

  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic              ctx_done;
  logic              w_done;

  // Round-robin scan starting at ptr; the first pending index wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!win_found && req_vld[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  // Only the owner sees ready, and only during the single ACCEPT cycle.
  always_comb begin
    req_rdy = '0;
    if (state == S_ACCEPT) begin
      req_rdy[grant_id] = 1'b1;
    end
  end

  // A handshake is finished once its valid has dropped or completes this cycle.
  assign ctx_done   = ~cmp_ctx_in_vld | cmp_ctx_in_rdy;
  assign w_done     = ~cmp_w_vld | cmp_w_rdy;

  assign cmp_ctx_in = ctx_buf;
  assign cmp_w      = w_buf;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      ptr             <= '0;
      grant_id        <= '0;
      jobs_done       <= '0;
      rsp_ctx         <= '0;
      rsp_vld         <= '0;
      ctx_buf         <= '0;
      w_buf           <= '0;
      cmp_ctx_in_vld  <= 1'b0;
      cmp_w_vld       <= 1'b0;
      cmp_ctx_out_rdy <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (win_found) begin
            grant_id <= win_id;
            state    <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          ctx_buf        <= req_ctx[grant_id];
          w_buf          <= req_w[grant_id];
          cmp_ctx_in_vld <= 1'b1;
          cmp_w_vld      <= 1'b1;
          state          <= S_ISSUE;
        end
        S_ISSUE: begin
          if (cmp_ctx_in_rdy) begin
            cmp_ctx_in_vld <= 1'b0;
          end
          if (cmp_w_rdy) begin
            cmp_w_vld <= 1'b0;
          end
          if (ctx_done && w_done) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cmp_ctx_out_vld) begin
            rsp_ctx         <= cmp_ctx_out;
            cmp_ctx_out_rdy <= 1'b1;
            state           <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          cmp_ctx_out_rdy <= 1'b0;
          rsp_vld         <= NUM_REQ'(1) << grant_id;
          state           <= S_RESPOND;
        end
        S_RESPOND: begin
          if (rsp_rdy[grant_id]) begin
            rsp_vld   <= '0;
            jobs_done <= jobs_done + 16'd1;
            ptr       <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msa_compressor_arbiter.sv
// Bench for msa_compressor_arbiter: a behavioural SHA-256 compressor stands
// in for msa_compressor; directed and random jobs are checked against a
// round-robin reference model.
module tb_msa_compressor_arbiter;
  import msa_compressor_arbiter_pkg::*;

  localparam int N = 4;

  logic                       clk;
  logic                       rst;
  logic [N-1:0]               req_vld;
  logic [N-1:0]               req_rdy;
  ShaContext [N-1:0]          req_ctx;
  logic [N-1:0][63:0][31:0]   req_w;
  logic [N-1:0]               rsp_vld;
  logic [N-1:0]               rsp_rdy;
  ShaContext                  rsp_ctx;
  logic                       cmp_ctx_in_vld;
  logic                       cmp_ctx_in_rdy;
  ShaContext                  cmp_ctx_in;
  logic                       cmp_w_vld;
  logic                       cmp_w_rdy;
  logic [63:0][31:0]          cmp_w;
  logic                       cmp_ctx_out_vld;
  logic                       cmp_ctx_out_rdy;
  ShaContext                  cmp_ctx_out;
  logic                       busy;
  logic [1:0]                 grant_id;
  logic [15:0]                jobs_done;

  msa_compressor_arbiter #(.NUM_REQ(N)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_vld         (req_vld),
    .req_rdy         (req_rdy),
    .req_ctx         (req_ctx),
    .req_w           (req_w),
    .rsp_vld         (rsp_vld),
    .rsp_rdy         (rsp_rdy),
    .rsp_ctx         (rsp_ctx),
    .cmp_ctx_in_vld  (cmp_ctx_in_vld),
    .cmp_ctx_in_rdy  (cmp_ctx_in_rdy),
    .cmp_ctx_in      (cmp_ctx_in),
    .cmp_w_vld       (cmp_w_vld),
    .cmp_w_rdy       (cmp_w_rdy),
    .cmp_w           (cmp_w),
    .cmp_ctx_out_vld (cmp_ctx_out_vld),
    .cmp_ctx_out_rdy (cmp_ctx_out_rdy),
    .cmp_ctx_out     (cmp_ctx_out),
    .busy            (busy),
    .grant_id        (grant_id),
    .jobs_done       (jobs_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // ---------------- SHA-256 reference ----------------
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0][31:0] sched(input logic [15:0][31:0] m);
    logic [63:0][31:0] w;
    logic [31:0] s0, s1;
    w = '0;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    return w;
  endfunction

  function automatic ShaContext sha_compress(input ShaContext ci, input logic [63:0][31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    ShaContext co;
    a = ci.state[0]; b = ci.state[1]; c = ci.state[2]; d = ci.state[3];
    e = ci.state[4]; f = ci.state[5]; g = ci.state[6]; h = ci.state[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    co.state[0] = ci.state[0] + a; co.state[1] = ci.state[1] + b;
    co.state[2] = ci.state[2] + c; co.state[3] = ci.state[3] + d;
    co.state[4] = ci.state[4] + e; co.state[5] = ci.state[5] + f;
    co.state[6] = ci.state[6] + g; co.state[7] = ci.state[7] + h;
    return co;
  endfunction

  // ---------------- compressor stand-in ----------------
  int                bfm_ctx_dly = 0;
  int                bfm_w_dly   = 0;
  int                bfm_lat     = 0;
  logic              got_c, got_w;
  int                cnt_c, cnt_w, cnt_l;
  ShaContext         cap_ctx;
  logic [63:0][31:0] cap_w;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_ctx_in_rdy  <= 1'b0;
      cmp_w_rdy       <= 1'b0;
      cmp_ctx_out_vld <= 1'b0;
      cmp_ctx_out     <= '0;
      got_c <= 1'b0; got_w <= 1'b0;
      cnt_c <= 0; cnt_w <= 0; cnt_l <= 0;
      cap_ctx <= '0; cap_w <= '0;
    end else begin
      if (cmp_ctx_in_vld && !got_c) begin
        if (cmp_ctx_in_rdy) begin
          got_c <= 1'b1; cap_ctx <= cmp_ctx_in; cmp_ctx_in_rdy <= 1'b0;
        end else if (cnt_c >= bfm_ctx_dly) cmp_ctx_in_rdy <= 1'b1;
        else cnt_c <= cnt_c + 1;
      end
      if (cmp_w_vld && !got_w) begin
        if (cmp_w_rdy) begin
          got_w <= 1'b1; cap_w <= cmp_w; cmp_w_rdy <= 1'b0;
        end else if (cnt_w >= bfm_w_dly) cmp_w_rdy <= 1'b1;
        else cnt_w <= cnt_w + 1;
      end
      if (cmp_ctx_out_vld) begin
        if (cmp_ctx_out_rdy) begin
          cmp_ctx_out_vld <= 1'b0;
          got_c <= 1'b0; got_w <= 1'b0;
          cnt_c <= 0; cnt_w <= 0; cnt_l <= 0;
        end
      end else if (got_c && got_w) begin
        if (cnt_l >= bfm_lat) begin
          cmp_ctx_out_vld <= 1'b1;
          cmp_ctx_out     <= sha_compress(cap_ctx, cap_w);
        end else cnt_l <= cnt_l + 1;
      end
    end
  end

  // ---------------- reference model ----------------
  int          m_ptr  = 0;
  logic [15:0] m_jobs = '0;

  function automatic int model_winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_rdy", 256'(req_rdy), '0);
    chk("rst_rsp_vld", 256'(rsp_vld), '0);
    chk("rst_busy", 256'(busy), '0);
    chk("rst_grant_id", 256'(grant_id), '0);
    chk("rst_jobs_done", 256'(jobs_done), '0);
    chk("rst_rsp_ctx", 256'(rsp_ctx), '0);
    chk("rst_cmp_ctx_in_vld", 256'(cmp_ctx_in_vld), '0);
    chk("rst_cmp_w_vld", 256'(cmp_w_vld), '0);
    chk("rst_cmp_ctx_out_rdy", 256'(cmp_ctx_out_rdy), '0);
    chk("rst_cmp_ctx_in", 256'(cmp_ctx_in), '0);
    chk("rst_cmp_w", 256'(|cmp_w), '0);
  endtask

  task automatic rand_req(input int i);
    for (int k = 0; k < 8; k++) req_ctx[i].state[k] = $urandom;
    for (int k = 0; k < 64; k++) req_w[i][k] = $urandom;
  endtask

  // Called at a negedge with the arbiter idle and at least one request pending.
  task automatic run_job(input bit drop_req, input logic [N-1:0] add_req, input int rsp_hold,
                         output int g, output ShaContext got, output int ctx_drop,
                         output int w_drop, output int rel_at);
    bit           seen;
    int           rel_len;
    ShaContext    exp_ctx;
    logic [N-1:0] others;
    g = model_winner(req_vld, m_ptr);
    if (g < 0) g = 0;
    exp_ctx = sha_compress(req_ctx[g], req_w[g]);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (req_rdy !== '0) seen = 1'b1;
      else chk("pre_grant_rsp_vld", 256'(rsp_vld), '0);
    end
    chk("grant_seen", 256'(seen), 256'(1));
    chk("req_rdy_onehot", 256'(req_rdy), 256'(1) << g);
    chk("grant_id", 256'(grant_id), 256'(g));
    chk("busy_accept", 256'(busy), 256'(1));
    @(posedge clk); #1;
    if (drop_req) req_vld[g] = 1'b0;
    req_vld = req_vld | add_req;
    chk("issue_ctx_vld", 256'(cmp_ctx_in_vld), 256'(1));
    chk("issue_w_vld", 256'(cmp_w_vld), 256'(1));
    chk("issue_ctx_data", 256'(cmp_ctx_in), 256'(req_ctx[g]));
    chk("issue_w_data", 256'(cmp_w === req_w[g]), 256'(1));
    ctx_drop = -1; w_drop = -1; rel_at = -1; rel_len = 0; seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (ctx_drop < 0 && !cmp_ctx_in_vld) ctx_drop = n;
      if (w_drop < 0 && !cmp_w_vld) w_drop = n;
      if (cmp_ctx_out_rdy) begin
        if (rel_at < 0) rel_at = n;
        rel_len++;
      end
      if (rsp_vld !== '0) seen = 1'b1;
      else chk("req_rdy_while_busy", 256'(req_rdy), '0);
    end
    chk("rsp_seen", 256'(seen), 256'(1));
    chk("rsp_vld_owner", 256'(rsp_vld), 256'(1) << g);
    chk("rsp_ctx", 256'(rsp_ctx), 256'(exp_ctx));
    chk("release_len", 256'(rel_len), 256'(1));
    others = '1;
    others[g] = 1'b0;
    for (int h = 0; h < rsp_hold; h++) begin
      rsp_rdy = others;
      @(negedge clk);
      chk("hold_rsp_vld", 256'(rsp_vld), 256'(1) << g);
      chk("hold_rsp_ctx", 256'(rsp_ctx), 256'(exp_ctx));
      chk("hold_req_rdy", 256'(req_rdy), '0);
    end
    got = rsp_ctx;
    rsp_rdy = '0;
    rsp_rdy[g] = 1'b1;
    @(negedge clk);
    rsp_rdy = '0;
    m_jobs = m_jobs + 16'd1;
    m_ptr  = (g + 1) % N;
    chk("jobs_done", 256'(jobs_done), 256'(m_jobs));
    chk("rsp_vld_clear", 256'(rsp_vld), '0);
    chk("busy_idle", 256'(busy), '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_vld = '0;
    rsp_rdy = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    m_ptr  = 0;
    m_jobs = '0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int                g, cd, wd, ra, r;
    bit                seen;
    ShaContext         got;
    logic [15:0][31:0] blk;
    logic [N-1:0]      nv;
    int                order_exp [5];

    rst = 1'b1; req_vld = '0; rsp_rdy = '0;
    for (int i = 0; i < N; i++) rand_req(i);

    // 1: "abc" block through requester 0
    do_reset();
    req_ctx[0].state[0] = 32'h6a09e667; req_ctx[0].state[1] = 32'hbb67ae85;
    req_ctx[0].state[2] = 32'h3c6ef372; req_ctx[0].state[3] = 32'ha54ff53a;
    req_ctx[0].state[4] = 32'h510e527f; req_ctx[0].state[5] = 32'h9b05688c;
    req_ctx[0].state[6] = 32'h1f83d9ab; req_ctx[0].state[7] = 32'h5be0cd19;
    blk = '0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    req_w[0] = sched(blk);
    req_vld = 4'b0001;
    run_job(1'b1, '0, 0, g, got, cd, wd, ra);
    chk("abc_state0", 256'(got.state[0]), 256'(32'hBA7816BF));
    chk("abc_jobs_done", 256'(jobs_done), 256'(1));

    // 2: all requesting, held; grant order from a fresh pointer
    do_reset();
    order_exp = '{0, 1, 2, 3, 0};
    req_vld = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      run_job(1'b0, '0, 0, g, got, cd, wd, ra);
      if (j == 4) req_vld = '0;
      chk("rr_order", 256'(g), 256'(order_exp[j]));
    end

    // 3: schedule handshake completes 5 cycles after the context handshake
    bfm_ctx_dly = 0; bfm_w_dly = 5; bfm_lat = 0;
    req_vld = 4'b0010;
    run_job(1'b1, '0, 0, g, got, cd, wd, ra);
    chk("split_ctx_first", 256'(cd < wd), 256'(1));
    chk("split_gap", 256'(wd - cd), 256'(5));
    chk("split_wait_after_both", 256'(ra > wd), 256'(1));
    bfm_w_dly = 0;

    // 4: stalled response, a second requester waits until it is released
    req_vld = 4'b0100;
    run_job(1'b1, 4'b0010, 10, g, got, cd, wd, ra);
    chk("stall_owner", 256'(g), 256'(2));
    run_job(1'b1, '0, 0, g, got, cd, wd, ra);
    chk("stall_next_owner", 256'(g), 256'(1));

    // 5: reset while the compressor is working
    bfm_lat = 30;
    req_vld = 4'b0100;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (req_rdy !== '0) seen = 1'b1;
    end
    chk("mid_grant_seen", 256'(seen), 256'(1));
    chk("mid_req_rdy", 256'(req_rdy), 256'(4'b0100));
    @(posedge clk); #1;
    req_vld = '0;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (busy && !cmp_ctx_in_vld && !cmp_w_vld) seen = 1'b1;
    end
    chk("mid_reached_wait", 256'(seen), 256'(1));
    repeat (3) @(negedge clk);
    chk("mid_still_busy", 256'(busy), 256'(1));
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    m_ptr = 0; m_jobs = '0; bfm_lat = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_vld = 4'b1010;
    run_job(1'b1, '0, 0, g, got, cd, wd, ra);
    req_vld = '0;
    chk("post_rst_ptr", 256'(g), 256'(1));

    // 6: counter wrap
    @(negedge clk);
    force dut.jobs_done = 16'hFFFF;
    @(negedge clk);
    release dut.jobs_done;
    m_jobs = 16'hFFFF;
    req_vld = 4'b0001;
    run_job(1'b1, '0, 0, g, got, cd, wd, ra);
    chk("jobs_wrap", 256'(jobs_done), '0);

    // random traffic
    for (int it = 0; it < 24; it++) begin
      nv = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        if (nv[i] && !req_vld[i]) rand_req(i);
      end
      req_vld = req_vld | nv;
      if (req_vld == '0) begin
        r = $urandom_range(0, N - 1);
        rand_req(r);
        req_vld[r] = 1'b1;
      end
      bfm_ctx_dly = $urandom_range(0, 3);
      bfm_w_dly   = $urandom_range(0, 3);
      bfm_lat     = $urandom_range(0, 6);
      run_job(1'b1, '0, $urandom_range(0, 3), g, got, cd, wd, ra);
    end
    req_vld = '0;
    repeat (3) @(negedge clk);
    chk("final_idle", 256'(busy), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
